// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between two requesters.
// Each accepted request runs IDLE -> EXEC -> RESP; results are registered per requester.
module alu_share_arbiter #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [W-1:0]     r0_a,
  input  logic [W-1:0]     r0_b,
  input  logic [2:0]       r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [W-1:0]     r0_res,
  output logic             r0_zero,
  output logic             r0_sign,
  // requester 1
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [W-1:0]     r1_a,
  input  logic [W-1:0]     r1_b,
  input  logic [2:0]       r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [W-1:0]     r1_res,
  output logic             r1_zero,
  output logic             r1_sign,
  // shared ALU
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_zero,
  input  logic             alu_sign,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [W-1:0]     res0_q, res0_d;
  logic [W-1:0]     res1_q, res1_d;
  logic             zero0_q, zero0_d;
  logic             zero1_q, zero1_d;
  logic             sign0_q, sign0_d;
  logic             sign1_q, sign1_d;

  logic grant0;
  logic grant1;
  logic owner_rsp_ready;

  // Ties go to the requester that did not win last time; last_grant_q resets to 1 so r0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (r0_req_valid && r1_req_valid) begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end else begin
        grant0 = r0_req_valid;
        grant1 = r1_req_valid;
      end
    end
  end

  assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    zero0_d      = zero0_q;
    zero1_d      = zero1_q;
    sign0_d      = sign0_q;
    sign1_d      = sign1_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          a_d          = grant1 ? r1_a  : r0_a;
          b_d          = grant1 ? r1_b  : r0_b;
          op_d         = grant1 ? r1_op : r0_op;
          if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CntOne;
          if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CntOne;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          res1_d  = alu_res;
          zero1_d = alu_zero;
          sign1_d = alu_sign;
        end else begin
          res0_d  = alu_res;
          zero0_d = alu_zero;
          sign0_d = alu_sign;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 3'b000;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      zero0_q      <= 1'b0;
      zero1_q      <= 1'b0;
      sign0_q      <= 1'b0;
      sign1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      zero0_q      <= zero0_d;
      zero1_q      <= zero1_d;
      sign0_q      <= sign0_d;
      sign1_q      <= sign1_d;
    end
  end

  // Latched operands only change when entering EXEC, so the ALU inputs hold steady otherwise.
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_ctrl     = op_q;

  assign r0_req_ready = grant0;
  assign r1_req_ready = grant1;
  assign r0_rsp_valid = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid = (state_q == RESP) && owner_q;
  assign r0_res       = res0_q;
  assign r0_zero      = zero0_q;
  assign r0_sign      = sign0_q;
  assign r1_res       = res1_q;
  assign r1_zero      = zero1_q;
  assign r1_sign      = sign1_q;

  assign busy         = (state_q != IDLE);
  assign grant_cnt0   = cnt0_q;
  assign grant_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, corner-case sequences and random traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];
  logic [2:0]  op_in [2];

  wire [1:0]  req_ready, rsp_valid, zero_o, sign_o;
  wire [31:0] res_o [2];
  wire [31:0] alu_a, alu_b, alu_res;
  wire [2:0]  alu_ctrl;
  wire        alu_zero, alu_sign, busy;
  wire [15:0] cnt0, cnt1;

  wire [1:0]  s_req_ready, s_rsp_valid, s_zero, s_sign;
  wire [31:0] s_res [2];
  wire [31:0] s_alu_a, s_alu_b, s_alu_res;
  wire [2:0]  s_alu_ctrl;
  wire        s_alu_zero, s_alu_sign, s_busy;
  wire [1:0]  s_cnt0, s_cnt1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b011:  return a ^ b;
      3'b100:  return (a < b) ? 32'd1 : 32'd0;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_res == 32'd0);
  assign alu_sign   = alu_res[31];
  assign s_alu_res  = alu_f(s_alu_a, s_alu_b, s_alu_ctrl);
  assign s_alu_zero = (s_alu_res == 32'd0);
  assign s_alu_sign = s_alu_res[31];

  alu_share_arbiter #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]), .r0_a(a_in[0]), .r0_b(b_in[0]),
    .r0_op(op_in[0]), .r0_rsp_valid(rsp_valid[0]), .r0_rsp_ready(rsp_ready[0]),
    .r0_res(res_o[0]), .r0_zero(zero_o[0]), .r0_sign(sign_o[0]),
    .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]), .r1_a(a_in[1]), .r1_b(b_in[1]),
    .r1_op(op_in[1]), .r1_rsp_valid(rsp_valid[1]), .r1_rsp_ready(rsp_ready[1]),
    .r1_res(res_o[1]), .r1_zero(zero_o[1]), .r1_sign(sign_o[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
    .alu_zero(alu_zero), .alu_sign(alu_sign),
    .busy(busy), .grant_cnt0(cnt0), .grant_cnt1(cnt1)
  );

  // Narrow-counter instance sharing all requester inputs, used for saturation checks.
  alu_share_arbiter #(.W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .r0_req_valid(req_valid[0]), .r0_req_ready(s_req_ready[0]), .r0_a(a_in[0]), .r0_b(b_in[0]),
    .r0_op(op_in[0]), .r0_rsp_valid(s_rsp_valid[0]), .r0_rsp_ready(rsp_ready[0]),
    .r0_res(s_res[0]), .r0_zero(s_zero[0]), .r0_sign(s_sign[0]),
    .r1_req_valid(req_valid[1]), .r1_req_ready(s_req_ready[1]), .r1_a(a_in[1]), .r1_b(b_in[1]),
    .r1_op(op_in[1]), .r1_rsp_valid(s_rsp_valid[1]), .r1_rsp_ready(rsp_ready[1]),
    .r1_res(s_res[1]), .r1_zero(s_zero[1]), .r1_sign(s_sign[1]),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_ctrl(s_alu_ctrl), .alu_res(s_alu_res),
    .alu_zero(s_alu_zero), .alu_sign(s_alu_sign),
    .busy(s_busy), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one in-flight transaction, result visible two cycles after accept.
  bit          m_active = 0;
  bit          m_inflight;
  int          m_age;
  int          m_owner;
  int          m_last;
  logic [31:0] m_la, m_lb;
  logic [2:0]  m_lop;
  logic [31:0] m_res [2];
  logic        m_zero [2];
  logic        m_sign [2];
  int          m_cnt [2];
  bit          e_g [2];

  // Values sampled on the falling edge.
  logic        i_rst;
  logic        i_v [2];
  logic        i_rr [2];
  logic [31:0] i_a [2];
  logic [31:0] i_b [2];
  logic [2:0]  i_op [2];
  logic        smp_ready [2];
  logic        smp_rsp_valid [2];
  logic [31:0] smp_res [2];
  logic        smp_zero [2];
  logic        smp_busy;
  int          smp_cnt [2];
  int          smp_scnt [2];
  logic [31:0] smp_alu_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic sample_and_check();
    int sat;
    i_rst = rst;
    for (int n = 0; n < 2; n++) begin
      i_v[n] = req_valid[n];  i_rr[n] = rsp_ready[n];
      i_a[n] = a_in[n];       i_b[n]  = b_in[n];     i_op[n] = op_in[n];
      smp_ready[n] = req_ready[n];  smp_rsp_valid[n] = rsp_valid[n];
      smp_res[n]   = res_o[n];      smp_zero[n]      = zero_o[n];
    end
    smp_cnt[0] = int'(cnt0);    smp_cnt[1] = int'(cnt1);
    smp_scnt[0] = int'(s_cnt0); smp_scnt[1] = int'(s_cnt1);
    smp_busy = busy; smp_alu_a = alu_a;
    if (!m_active) return;
    e_g[0] = 0; e_g[1] = 0;
    if (!m_inflight) begin
      if (i_v[0] && i_v[1]) e_g[1 - m_last] = 1;
      else begin e_g[0] = i_v[0]; e_g[1] = i_v[1]; end
    end
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("r%0d_req_ready", n), 64'(req_ready[n]), 64'(e_g[n]));
      chk($sformatf("r%0d_rsp_valid", n), 64'(rsp_valid[n]),
          64'(m_inflight && m_age == 2 && m_owner == n));
      chk($sformatf("r%0d_res", n), 64'(res_o[n]), 64'(m_res[n]));
      chk($sformatf("r%0d_zero", n), 64'(zero_o[n]), 64'(m_zero[n]));
      chk($sformatf("r%0d_sign", n), 64'(sign_o[n]), 64'(m_sign[n]));
      chk($sformatf("grant_cnt%0d", n), 64'(smp_cnt[n]), 64'(m_cnt[n]));
      sat = (m_cnt[n] > 3) ? 3 : m_cnt[n];
      chk($sformatf("sat_grant_cnt%0d", n), 64'(smp_scnt[n]), 64'(sat));
    end
    chk("busy", 64'(busy), 64'(m_inflight));
    chk("alu_a", 64'(alu_a), 64'(m_la));
    chk("alu_b", 64'(alu_b), 64'(m_lb));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(m_lop));
  endtask

  task automatic model_update();
    if (i_rst) begin
      m_active = 1; m_inflight = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_la = '0; m_lb = '0; m_lop = '0;
      for (int n = 0; n < 2; n++) begin
        m_res[n] = '0; m_zero[n] = 0; m_sign[n] = 0; m_cnt[n] = 0;
      end
    end else if (m_active) begin
      if (m_inflight && m_age == 1) begin
        m_res[m_owner]  = alu_f(m_la, m_lb, m_lop);
        m_zero[m_owner] = (m_res[m_owner] == 32'd0);
        m_sign[m_owner] = m_res[m_owner][31];
        m_age = 2;
      end else if (m_inflight) begin
        if (i_rr[m_owner]) m_inflight = 0;
      end else if (e_g[0] || e_g[1]) begin
        m_owner = e_g[1] ? 1 : 0;
        m_la = i_a[m_owner]; m_lb = i_b[m_owner]; m_lop = i_op[m_owner];
        m_last = m_owner;
        if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
        m_inflight = 1; m_age = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; rsp_ready = '0;
    step(); step();
    rst = 0;
  endtask

  task automatic wait_accept(input int n, output int k);
    k = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (smp_ready[n] && i_v[n]) begin k = i; break; end
    end
    if (k < 0) chk($sformatf("accept_timeout_r%0d", n), 64'(0), 64'(1));
  endtask

  task automatic wait_rsp(input int n, output int k);
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (smp_rsp_valid[n]) begin k = i; break; end
    end
    if (k < 0) chk($sformatf("rsp_timeout_r%0d", n), 64'(0), 64'(1));
  endtask

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        sign;
  } vec_t;

  task automatic do_txn(input vec_t v);
    int k;
    req_valid[v.n] = 1; a_in[v.n] = v.a; b_in[v.n] = v.b; op_in[v.n] = v.op;
    rsp_ready[v.n] = 1;
    wait_accept(v.n, k);
    chk("accept_first_cycle", 64'(k), 64'(0));
    req_valid[v.n] = 0;
    if (k < 0) return;
    wait_rsp(v.n, k);
    chk("rsp_latency", 64'(k), 64'(2));
    chk("vec_res", 64'(smp_res[v.n]), 64'(v.res));
    chk("vec_zero", 64'(smp_zero[v.n]), 64'(v.zero));
    chk("vec_sign", 64'(res_o[v.n][31]), 64'(v.sign));
  endtask

  initial begin
    vec_t vt [9];
    vec_t v;
    int   order [$];
    int   k;
    int   exp_order [4];

    rst = 1; req_valid = '0; rsp_ready = '0;
    for (int n = 0; n < 2; n++) begin a_in[n] = '0; b_in[n] = '0; op_in[n] = '0; end

    vt[0] = '{0, 32'd5,         32'hFFFF_FFF9, 3'b010, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vt[1] = '{1, 32'd1,         32'hFFFF_FFFF, 3'b100, 32'd1,         1'b0, 1'b0};
    vt[2] = '{1, 32'd1,         32'hFFFF_FFFF, 3'b111, 32'd0,         1'b1, 1'b0};
    vt[3] = '{0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 32'h00F0_000F, 1'b0, 1'b0};
    vt[4] = '{1, 32'hF000_0000, 32'h0000_000F, 3'b001, 32'hF000_000F, 1'b0, 1'b1};
    vt[5] = '{0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 3'b011, 32'd0,         1'b1, 1'b0};
    vt[6] = '{1, 32'd3,         32'd5,         3'b110, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vt[7] = '{0, 32'd123,       32'd456,       3'b101, 32'd0,         1'b1, 1'b0};
    vt[8] = '{1, 32'h7FFF_FFFF, 32'd1,         3'b010, 32'h8000_0000, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) do_txn(vt[i]);

    // Both requesters valid continuously: strict alternation starting with r0.
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 30 && order.size() < 4; i++) begin
      step();
      if (smp_ready[0] && i_v[0]) order.push_back(0);
      if (smp_ready[1] && i_v[1]) order.push_back(1);
    end
    req_valid = 2'b00;
    exp_order = '{0, 1, 0, 1};
    chk("rr_grant_count", 64'(order.size()), 64'(4));
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("rr_grant_%0d", i), 64'(order[i]), 64'(exp_order[i]));
    step();
    chk("rr_cnt0", 64'(smp_cnt[0]), 64'(2));
    chk("rr_cnt1", 64'(smp_cnt[1]), 64'(2));
    repeat (4) step();

    // Response backpressure: result held stable, r1 stalled until release.
    req_valid[0] = 1; a_in[0] = 32'd9; b_in[0] = 32'd9; op_in[0] = 3'b110; rsp_ready[0] = 0;
    wait_accept(0, k);
    req_valid[0] = 0;
    req_valid[1] = 1; a_in[1] = 32'd1; b_in[1] = 32'd2; op_in[1] = 3'b010; rsp_ready[1] = 1;
    wait_rsp(0, k);
    repeat (5) begin
      step();
      chk("hold_rsp_valid", 64'(smp_rsp_valid[0]), 64'(1));
      chk("hold_res", 64'(smp_res[0]), 64'(0));
      chk("hold_zero", 64'(smp_zero[0]), 64'(1));
      chk("hold_r1_stalled", 64'(smp_ready[1]), 64'(0));
    end
    rsp_ready[0] = 1;
    step();
    wait_accept(1, k);
    chk("r1_after_release", 64'(k), 64'(0));
    req_valid[1] = 0;
    wait_rsp(1, k);
    chk("r1_res_after_release", 64'(smp_res[1]), 64'(3));
    step();

    // Reset during EXEC drops the transaction.
    req_valid[1] = 1; a_in[1] = 32'd40; b_in[1] = 32'd2; op_in[1] = 3'b010;
    wait_accept(1, k);
    req_valid[1] = 0;
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", 64'(smp_busy), 64'(0));
      chk("rst_rsp_valid1", 64'(smp_rsp_valid[1]), 64'(0));
      chk("rst_res1", 64'(smp_res[1]), 64'(0));
      chk("rst_alu_a", 64'(smp_alu_a), 64'(0));
      chk("rst_cnt1", 64'(smp_cnt[1]), 64'(0));
    end
    v = '{1, 32'd40, 32'd2, 3'b010, 32'd42, 1'b0, 1'b0};
    do_txn(v);

    // Saturation of the 2-bit counter after five grants to r0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = '{0, 32'(i), 32'd1, 3'b010, 32'(i + 1), 1'b0, 1'b0};
      do_txn(v);
    end
    step();
    chk("sat_cnt0_final", 64'(smp_scnt[0]), 64'(3));
    chk("wide_cnt0_final", 64'(smp_cnt[0]), 64'(5));

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int n = 0; n < 2; n++) begin
        req_valid[n] = ($urandom_range(0, 2) != 0);
        rsp_ready[n] = ($urandom_range(0, 2) != 0);
        a_in[n]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        b_in[n]  = ($urandom_range(0, 3) == 0) ? a_in[n] : $urandom;
        op_in[n] = 3'($urandom_range(0, 7));
      end
      step();
    end
    rst = 0; req_valid = '0; rsp_ready = 2'b11;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
